alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, registered successor of the team's 4-bit combinational ALU.
- Accepts one operation per valid/ready handshake. Supports add/sub with carry-in, the logic ops, variable-distance shifts and rotates, and an iterative unsigned multiply.
- Outputs a registered result plus status flags, held until the consumer accepts it.
- Sits between the operand/decode stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), width of the shift/rotate distance taken from B[SHW-1:0]. Derived; do not override.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept an operation.
- op  in  4  operation code (encoding under Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B, or shift distance in B[SHW-1:0].
- cin  in  1  carry/borrow in; used by ADD/SUB only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result (low half for MUL).
- result_hi  out  WIDTH  high half of the MUL product; 0 for all other ops.
- cout  out  1  carry (ADD) or borrow (SUB); 0 otherwise.
- zero  out  1  result == 0. For MUL, set when {result_hi, result} == 0.
- neg  out  1  result[WIDTH-1].
- ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- illegal  out  1  op code was undefined.

Behaviour:
- Reset: state IDLE. out_valid=0, result=0, result_hi=0, all flags=0, in_ready=1 in the cycle after reset. Reset mid-operation aborts the multiply and drops any held result.
- Op encoding:
  - 0 ADD: {cout,result}=a+b+cin.
  - 1 SUB: result=a-b-cin; cout=1 on borrow.
  - 2 OR.
  - 3 AND.
  - 4 XOR.
  - 5 SHL: logical, by b[SHW-1:0].
  - 6 SHR: logical.
  - 7 SRA: arithmetic right.
  - 8 ROL.
  - 9 ROR.
  - 10 MUL: unsigned, 2·WIDTH-bit product.
  - 11–15: illegal. result=0, illegal=1, treated as a single-cycle op.
- Shift/rotate distance 0 returns a unchanged. Upper bits of b beyond SHW are ignored.
- ovf: ADD → sign(a)==sign(b) && sign(result)!=sign(a). SUB → sign(a)!=sign(b) && sign(result)!=sign(a). cin is included in both.
- States:
  - IDLE: in_ready=1. On accept of a non-MUL op → DONE next cycle with the registered result (latency 1). On accept of MUL → BUSY, with a, b captured and accumulator and counter cleared.
  - BUSY: in_ready=0. Shift-and-add, one bit of b per cycle, for exactly WIDTH cycles. After the last iteration → DONE. MUL latency is WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1. result, result_hi and flags are stable until out_ready.
    - out_ready=1 with no new accept → IDLE.
    - in_ready = out_ready in DONE, so back-to-back ops are allowed: if out_ready && in_valid, the new op is accepted in the same cycle. A single-cycle op stays in DONE with the new result; MUL → BUSY.
- Inputs are sampled only on an accept cycle. Input changes at any other time have no effect.
- out_valid never drops without out_ready (no retraction).

Decomposition:
- Package alu_pkg holds:
  - op_e enum with the 11 codes plus OP_ILLEGAL_MIN.
  - state_e {IDLE, BUSY, DONE}.
  - flags struct {cout, zero, neg, ovf, illegal}.
- Sub-module alu_mul_iter: WIDTH-cycle shift-add multiplier with start/done pins. The parent keeps the FSM, the combinational op mux and the output registers.

Test Plan:
- WIDTH=8. ADD a=8'h7F, b=8'h01, cin=0 → result=8'h80, neg=1, ovf=1, cout=0, out_valid exactly 1 cycle after accept.
- SUB a=8'h00, b=8'h01, cin=1 → result=8'hFE, cout=1, ovf=0. ADD a=8'hFF, b=8'h01, cin=0 → result=0, zero=1, cout=1.
- Shifts/rotates, a=8'h96:
  - SRA b=3 → 8'hF2.
  - ROL b=3 → 8'hB4.
  - ROR b=8'h0B (distance 3) → 8'hD2.
  - SHL b=0 → 8'h96.
- MUL a=8'hFF, b=8'hFF → {result_hi,result}=16'hFE01, out_valid 9 cycles after accept, in_ready=0 throughout BUSY. MUL a=0 → zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an OR result → outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND) → both handshakes in one cycle, AND result next cycle. op=4'hC → illegal=1, result=0.
- Assert rst at cycle 3 of a MUL → next cycle: out_valid=0, in_ready=1, all outputs 0. A following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the registered ALU (alu_pipe) and its iterative
// multiplier (alu_mul_iter).
//   op_e    : 4-bit operation codes; codes >= OP_ILLEGAL_MIN are undefined
//   state_e : control FSM states
//   flags_t : status flags held alongside the registered result
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD         = 4'd0,
      OP_SUB         = 4'd1,
      OP_OR          = 4'd2,
      OP_AND         = 4'd3,
      OP_XOR         = 4'd4,
      OP_SHL         = 4'd5,
      OP_SHR         = 4'd6,
      OP_SRA         = 4'd7,
      OP_ROL         = 4'd8,
      OP_ROR         = 4'd9,
      OP_MUL         = 4'd10,
      OP_ILLEGAL_MIN = 4'd11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic cout;
      logic zero;
      logic neg;
      logic ovf;
      logic illegal;
   } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-and-add multiplier, one bit of b per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : capture a_i/b_i and begin (ignored while busy)
//   a_i, b_i   : WIDTH-bit unsigned operands
//   done_o     : high during the final iteration cycle
//   prod_o     : 2*WIDTH-bit product, valid while done_o is high
// The product is presented combinationally during the last iteration so the
// parent can register it on the same edge, giving exactly WIDTH busy cycles.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);

   localparam int CW = $clog2(WIDTH);

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;   // holds remaining multiplier bits, fills with product low bits
   logic [WIDTH:0]   sum_d;
   logic [2*WIDTH-1:0] prod_d;

   // {hi,lo} shifts right each step; the adder carry becomes the new top bit.
   always_comb begin
      sum_d  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
      prod_d = {sum_d, lo_q[WIDTH-1:1]};
   end

   assign done_o = busy_q && (cnt_q == CW'(WIDTH-1));
   assign prod_o = prod_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (start_i && !busy_q) begin
         busy_q  <= 1'b1;
         cnt_q   <= '0;
         mcand_q <= a_i;
         hi_q    <= '0;
         lo_q    <= b_i;
      end else if (busy_q) begin
         {hi_q, lo_q} <= prod_d;
         cnt_q        <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operation handshake (op, a, b, cin sampled on accept)
//   out_valid / out_ready : result handshake; outputs held until accepted
//   result, result_hi     : result (MUL: low/high product halves; hi=0 otherwise)
//   cout, zero, neg, ovf, illegal : status flags registered with the result
// Single-cycle ops produce out_valid the cycle after accept; MUL spends
// WIDTH cycles in BUSY. In DONE, in_ready follows out_ready so a new op can
// be accepted in the same cycle the old result is consumed.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             illegal
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   flags_t             flags_q, flags_d;

   logic               accept, is_mul, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [SHW-1:0]     sh;
   logic [WIDTH:0]     add_s, sub_s;
   logic [2*WIDTH-1:0] rol_s, ror_s;
   logic [WIDTH-1:0]   alu_res;
   flags_t             alu_fl;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (op == OP_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start_i (accept && is_mul),
      .a_i     (a),
      .b_i     (b),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   // Combinational single-cycle datapath
   assign sh    = b[SHW-1:0];
   assign add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign sub_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
   // Rotates via a doubled operand: the wanted window falls out of one shift.
   assign rol_s = {a, a} << sh;
   assign ror_s = {a, a} >> sh;

   always_comb begin
      alu_res = '0;
      alu_fl  = '0;
      case (op)
         OP_ADD: begin
            alu_res     = add_s[WIDTH-1:0];
            alu_fl.cout = add_s[WIDTH];
            alu_fl.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res     = sub_s[WIDTH-1:0];
            alu_fl.cout = sub_s[WIDTH];   // wraps negative on borrow
            alu_fl.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_OR:   alu_res = a | b;
         OP_AND:  alu_res = a & b;
         OP_XOR:  alu_res = a ^ b;
         OP_SHL:  alu_res = a << sh;
         OP_SHR:  alu_res = a >> sh;
         OP_SRA:  alu_res = $signed(a) >>> sh;
         OP_ROL:  alu_res = rol_s[2*WIDTH-1:WIDTH];
         OP_ROR:  alu_res = ror_s[WIDTH-1:0];
         OP_MUL:  alu_res = '0;            // handled by u_mul
         default: alu_fl.illegal = 1'b1;
      endcase
      alu_fl.zero = (alu_res == '0);
      alu_fl.neg  = alu_res[WIDTH-1];
   end

   // FSM and output register next-state
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      flags_d     = flags_q;
      case (state_q)
         IDLE: if (accept) state_d = is_mul ? BUSY : DONE;
         BUSY: if (mul_done) state_d = DONE;
         DONE: if (out_ready) state_d = accept ? (is_mul ? BUSY : DONE) : IDLE;
         default: state_d = IDLE;
      endcase
      if (accept && !is_mul) begin
         result_d    = alu_res;
         result_hi_d = '0;
         flags_d     = alu_fl;
      end else if (mul_done) begin
         result_d     = mul_prod[WIDTH-1:0];
         result_hi_d  = mul_prod[2*WIDTH-1:WIDTH];
         flags_d      = '0;
         flags_d.zero = (mul_prod == '0);
         flags_d.neg  = mul_prod[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         flags_q     <= flags_d;
      end
   end

   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign cout      = flags_q.cout;
   assign zero      = flags_q.zero;
   assign neg       = flags_q.neg;
   assign ovf       = flags_q.ovf;
   assign illegal   = flags_q.illegal;

endmodule
